instruction_fetch_unit: RTL and testbench

- Fetch stage directly upstream of instruction decode in the pipelined RV32I core.
- Issues in-order word requests to a variable-latency instruction memory and buffers returned instructions, each tagged with its PC, in a small FIFO.
- Presents them to decode with a valid/ready handshake.
- Accepts a redirect (branch mispredict or jump) that flushes buffered work and discards in-flight responses.

---
 rtl/instruction_fetch_unit.sv | 156 +++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: issues in-order word requests to instruction memory under a credit limit, buffers
// {pc, instruction} pairs in a FIFO for decode, and flushes on redirect. Optional perf counters: FETCH_PERF_COUNTERS_EN.
`timescale 1ns/1ps

module instruction_fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instruction
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0]     stall_cycles,
    output logic [31:0]     flush_count
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic            credit_ok;
    logic            req_fire;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] redirect_pc_aligned;
    logic            unused_redirect_lsbs;

    assign redirect_pc_aligned  = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Credit counts only registered occupancy, so a same-cycle pop never frees a slot.
    assign credit_ok = ({1'b0, count_q} + {1'b0, outstanding_q}) < (CW+1)'(DEPTH);
    assign req_fire  = imem_req_valid && imem_req_ready;
    assign push      = reset && !redirect && imem_resp_valid && (drop_q == '0);
    assign pop       = out_valid && out_ready;

    always_comb begin
        imem_req_valid  = reset && !redirect && credit_ok;
        imem_req_addr   = fetch_pc_q;
        out_valid       = reset && !redirect && (count_q != '0);
        out_pc          = reset ? mem_q[rd_ptr_q].pc    : '0;
        out_instruction = reset ? mem_q[rd_ptr_q].instr : 32'h0;
    end

    always_comb begin
        // NOTE: every _d takes its _q value first so no branch can leave it unassigned (no latch).
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        count_d       = count_q;
        drop_d        = drop_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_resp_valid);

        if (redirect) begin
            // Everything still in flight after this cycle belongs to the old path.
            fetch_pc_d = redirect_pc_aligned;
            resp_pc_d  = redirect_pc_aligned;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            drop_d     = outstanding_d;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (imem_resp_valid && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
            if (push) begin
                resp_pc_d = resp_pc_q + XLEN'(4);
                wr_ptr_d  = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            count_q       <= '0;
            outstanding_q <= '0;
            drop_q        <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // NOTE: FIFO storage is not reset; count_q alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {resp_pc_q, imem_resp_data};
        end
    end

`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] stall_q;
    logic [31:0] flush_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (out_ready && !out_valid) begin
                stall_q <= stall_q + 32'd1;
            end
            if (redirect) begin
                flush_q <= flush_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: a queue-based model of memory, in-flight requests and the
// decode buffer predicts every handshake, address and output entry cycle by cycle.
`timescale 1ns/1ps

module tb_instruction_fetch_unit;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instruction;
`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
`endif

    instruction_fetch_unit #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_instruction (out_instruction)
`ifdef FETCH_PERF_COUNTERS_EN
        ,
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    req_t        inflight[$];
    ent_t        buf_m[$];
    int          stale_n;
    int          cyc;
    int          lat_min;
    int          lat_max;
    int          vectors;
    int          miscompares;
    int          accepts_seen;
    logic [31:0] exp_fetch;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // One clock cycle: drive at the negedge, compare just after, advance the model at the posedge.
    task automatic step(input logic rst, input logic redir, input logic [31:0] rpc,
                        input logic rq_rdy, input logic o_rdy);
        logic resp_now;
        logic exp_req_v;
        logic exp_out_v;
        req_t r;
        reset          = rst;
        redirect       = redir;
        redirect_pc    = rpc;
        imem_req_ready = rq_rdy;
        out_ready      = o_rdy;
        resp_now       = rst && (inflight.size() > 0) && (cyc >= inflight[0].due);
        imem_resp_valid = resp_now;
        imem_resp_data  = resp_now ? mem_word(inflight[0].addr) : $urandom;
        #1;
        exp_req_v = rst && !redir && ((buf_m.size() + inflight.size()) < DEPTH);
        exp_out_v = rst && !redir && (buf_m.size() > 0);
        check("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_req_v});
        if (exp_req_v) check("req_addr", imem_req_addr, exp_fetch);
        check("out_valid", {31'b0, out_valid}, {31'b0, exp_out_v});
        if (exp_out_v) begin
            check("out_pc", out_pc, buf_m[0].pc);
            check("out_instruction", out_instruction, buf_m[0].instr);
        end else if (!rst) begin
            check("rst_out_pc", out_pc, 32'h0);
            check("rst_out_instruction", out_instruction, 32'h0);
        end
        if (imem_req_valid && rq_rdy) accepts_seen++;
        @(posedge clk);
        if (!rst) begin
            buf_m.delete();
            inflight.delete();
            stale_n   = 0;
            exp_fetch = RESET_PC;
        end else if (redir) begin
            if (resp_now) begin
                r = inflight.pop_front();
                if (stale_n > 0) stale_n--;
            end
            stale_n   = inflight.size();
            buf_m.delete();
            exp_fetch = rpc & 32'hFFFF_FFFC;
        end else begin
            if (exp_out_v && o_rdy) void'(buf_m.pop_front());
            if (resp_now) begin
                r = inflight.pop_front();
                if (stale_n > 0) stale_n--;
                else buf_m.push_back('{pc: r.addr, instr: mem_word(r.addr)});
            end
            if (exp_req_v && rq_rdy) begin
                inflight.push_back('{addr: exp_fetch, due: cyc + $urandom_range(lat_max, lat_min)});
                exp_fetch = exp_fetch + 32'd4;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        accepts_seen = 0;
        stale_n      = 0;
        cyc          = 0;
        lat_min      = 1;
        lat_max      = 1;
        exp_fetch    = RESET_PC;
        reset        = 1'b0;
        redirect     = 1'b0;
        redirect_pc  = '0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        out_ready    = 1'b0;
        @(negedge clk);

        // Reset state, then streaming at latency 1 with both sides always ready.
        repeat (3) step(1'b0, 1'b1, 32'h0000_0080, 1'b1, 1'b1);
        repeat (12) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);

        // Decode stalled: exactly DEPTH requests are accepted, then fetch resumes after draining.
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        accepts_seen = 0;
        repeat (10) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        check("fill_accepts", accepts_seen, 32'd4);
        repeat (10) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);

        // Latency 3, three requests in flight, redirect to 0x40.
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        lat_min = 3;
        lat_max = 3;
        repeat (3) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 32'h0000_0040, 1'b1, 1'b1);
        repeat (10) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);

        // Misaligned redirect target is truncated to a word boundary.
        step(1'b1, 1'b1, 32'h0000_0047, 1'b1, 1'b1);
        repeat (8) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);

        // Back-to-back redirects with requests in flight.
        repeat (2) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 32'h0000_0100, 1'b1, 1'b1);
        step(1'b1, 1'b1, 32'h0000_0200, 1'b1, 1'b1);
        repeat (12) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);

        // Fetch address wraps from the top of the address space.
        lat_min = 1;
        lat_max = 2;
        step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
        repeat (10) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);

        // Reset asserted mid-stream, fetch restarts at RESET_PC.
        repeat (2) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        repeat (10) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);

        // Randomized traffic: variable latency, backpressure, redirects and occasional resets.
        lat_min = 1;
        lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            logic        rst_r;
            logic        redir_r;
            logic [31:0] pc_r;
            rst_r   = ($urandom_range(199, 0) != 0);
            redir_r = ($urandom_range(99, 0) < 3);
            pc_r    = $urandom;
            step(rst_r, redir_r, pc_r, ($urandom_range(3, 0) != 0), ($urandom_range(9, 0) < 7));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
